pipe_stage_hs: RTL and testbench

// - Parametrised pipeline stage register with valid/ready handshake and an optional skid buffer.
// - Carries PC, PC+8, branch-delay flag, exception code and a generic payload (instr/operands/ext).
// - Supports a flush to bubble (clr) and an exception redirect (req).
// - Placed between any two stages of the 5-stage core (D->E, E->M, M->W).

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_stage_hs_if.sv | 20 ++
 rtl/pipe_skid_buf.sv | 33 +++
 rtl/pipe_stage_hs.sv | 121 ++++++++++++
 tb/tb_pipe_stage_hs.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register and its skid buffer.
package pipe_pkg;

  localparam int PAYLOAD_W_DEF = 128;
  localparam int EXC_W_DEF     = 5;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
  localparam logic [31:0] PC_STEP8     = 32'd8;

  typedef logic [EXC_W_DEF-1:0] exc_code_t;
  localparam exc_code_t EXC_NONE = '0;

  typedef struct packed {
    logic [31:0]              pc;
    logic                     bd;
    exc_code_t                exc;
    logic [PAYLOAD_W_DEF-1:0] payload;
  } stage_entry_t;

  // Wraps modulo 2^32, so 32'hFFFF_FFFC + 8 gives 32'h0000_0004.
  function automatic logic [31:0] pc_plus8(input logic [31:0] pc);
    return pc + PC_STEP8;
  endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Handshake bundle carrying one pipeline entry between two stages.
interface pipe_stage_hs_if #(
  parameter int PAYLOAD_W = 128,
  parameter int EXC_W     = 5
);

  // A beat transfers on a posedge where valid & ready are both high; ready may
  // depend on state only (skid build) or on the consumer's ready (no-skid build).
  logic                 valid;
  logic                 ready;
  logic [31:0]          pc;
  logic [31:0]          pc8;
  logic                 bd;
  logic [EXC_W-1:0]     exc;
  logic [PAYLOAD_W-1:0] payload;

  modport master (output valid, pc, pc8, bd, exc, payload, input ready);
  modport slave  (input valid, pc, pc8, bd, exc, payload, output ready);

endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry holding register that catches an input accepted while the main register is stalled.
module pipe_skid_buf #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] entry_in,
  output logic [W-1:0] entry_out,
  output logic         full
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_out <= '0;
    end else if (load) begin
      entry_out <= entry_in;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, flush (clr) and exception redirect (req).
// Optional 1-entry skid buffer enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int          PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int          EXC_W     = EXC_W_DEF,
  parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             clr,
  pipe_stage_hs_if.slave   up,
  pipe_stage_hs_if.master  dn
);

  typedef struct packed {
    logic [31:0]          pc;
    logic                 bd;
    logic [EXC_W-1:0]     exc;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t      in_entry;
  entry_t      src_entry;
  entry_t      nxt_entry;
  entry_t      main_q;
  logic [31:0] main_pc8;
  logic        main_valid;
  logic        nxt_valid;
  logic        src_valid;
  logic        in_ready;
  logic        accept;
  logic        main_load_en;
  logic        main_upd;

  assign in_entry.pc      = up.pc;
  assign in_entry.bd      = up.bd;
  assign in_entry.exc     = up.exc;
  assign in_entry.payload = up.payload;

  assign main_load_en = dn.ready | ~main_valid;
  assign accept       = up.valid & in_ready;
  assign up.ready     = in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic                      skid_full;
  logic [$bits(entry_t)-1:0] skid_raw;
  entry_t                    skid_q;

  // in_ready comes straight from a flop, so out_ready never reaches upstream combinationally.
  assign in_ready = ~skid_full;
  assign skid_q   = entry_t'(skid_raw);

  pipe_skid_buf #(
    .W ($bits(entry_t))
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (req | clr),
    .load      (accept & ~main_load_en),
    .unload    (main_load_en & skid_full),
    .entry_in  (in_entry),
    .entry_out (skid_raw),
    .full      (skid_full)
  );

  // The skid, when full, is older than anything upstream and drains first.
  assign src_valid = skid_full | accept;
  assign src_entry = skid_full ? skid_q : in_entry;
`else
  assign in_ready  = main_load_en;
  assign src_valid = accept;
  assign src_entry = in_entry;
`endif

  // Bubbles keep pc/bd of the current entry (needed for EPC) but clear exc and payload.
  always_comb begin
    nxt_valid         = 1'b0;
    nxt_entry         = main_q;
    nxt_entry.exc     = '0;
    nxt_entry.payload = '0;
    if (req) begin
      nxt_entry.pc = EXC_VEC;
      nxt_entry.bd = 1'b0;
    end else if (clr) begin
      nxt_entry.pc = up.pc;
      nxt_entry.bd = up.bd;
    end else if (src_valid) begin
      nxt_valid = 1'b1;
      nxt_entry = src_entry;
    end
  end

  assign main_upd = req | clr | main_load_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid     <= 1'b0;
      main_q.pc      <= PC_RESET;
      main_q.bd      <= 1'b0;
      main_q.exc     <= '0;
      main_q.payload <= '0;
      main_pc8       <= pc_plus8(PC_RESET);
    end else if (main_upd) begin
      main_valid <= nxt_valid;
      main_q     <= nxt_entry;
      main_pc8   <= pc_plus8(nxt_entry.pc);
    end
  end

  assign dn.valid   = main_valid;
  assign dn.pc      = main_q.pc;
  assign dn.pc8     = main_pc8;
  assign dn.bd      = main_q.bd;
  assign dn.exc     = main_q.exc;
  assign dn.payload = main_q.payload;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: vector table, hand-written stall/flush sequences, random run against a FIFO model.
module tb_pipe_stage_hs;
  import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam logic [31:0] PC_RST = 32'h0000_3000;
  localparam logic [31:0] PC_VEC = 32'h0000_4180;

  // clock / reset
  logic clk;
  logic reset;
  logic req;
  logic clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_hs_if #(.PAYLOAD_W(128), .EXC_W(5)) up_if ();
  pipe_stage_hs_if #(.PAYLOAD_W(128), .EXC_W(5)) dn_if ();

  pipe_stage_hs dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .clr   (clr),
    .up    (up_if),
    .dn    (dn_if)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] epc8, input logic ebd, input logic [4:0] eexc,
                           input logic [127:0] epl, input logic erdy);
    chk({tag, ".out_valid"}, 128'(dn_if.valid), 128'(ev));
    chk({tag, ".out_pc"}, 128'(dn_if.pc), 128'(epc));
    chk({tag, ".out_pc8"}, 128'(dn_if.pc8), 128'(epc8));
    chk({tag, ".out_bd"}, 128'(dn_if.bd), 128'(ebd));
    chk({tag, ".out_exc"}, 128'(dn_if.exc), 128'(eexc));
    chk({tag, ".out_payload"}, dn_if.payload, epl);
    chk({tag, ".in_ready"}, 128'(up_if.ready), 128'(erdy));
  endtask

  task automatic hc(input string tag, input logic ev, input logic [31:0] epc, input logic ebd,
                    input logic [127:0] epl, input logic erdy);
    check_out(tag, ev, epc, epc + 32'd8, ebd, 5'd0, epl, erdy);
  endtask

  // driver
  task automatic drive(input logic rst, input logic rq, input logic cl, input logic iv,
                       input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                       input logic [127:0] pl, input logic ordy);
    reset           = rst;
    req             = rq;
    clr             = cl;
    up_if.valid     = iv;
    up_if.pc        = pc;
    up_if.pc8       = pc + 32'd8;
    up_if.bd        = bd;
    up_if.exc       = exc;
    up_if.payload   = pl;
    dn_if.ready     = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pl_of(input logic [31:0] pc);
    return {pc, ~pc, pc ^ 32'h5a5a_5a5a, 32'hc0de_0000 | pc};
  endfunction

  // vector table
  typedef struct {
    logic         rst, rq, cl, iv;
    logic [31:0]  pc;
    logic         bd;
    logic [4:0]   exc;
    logic [127:0] pl;
    logic         e_valid;
    logic [31:0]  e_pc, e_pc8;
    logic         e_bd;
    logic [4:0]   e_exc;
    logic [127:0] e_pl;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic rst, input logic rq, input logic cl, input logic iv,
                              input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                              input logic [127:0] pl, input logic ev, input logic [31:0] epc,
                              input logic [31:0] epc8, input logic ebd, input logic [4:0] eexc,
                              input logic [127:0] epl);
    vec_t v;
    v.rst = rst; v.rq = rq; v.cl = cl; v.iv = iv; v.pc = pc; v.bd = bd; v.exc = exc; v.pl = pl;
    v.e_valid = ev; v.e_pc = epc; v.e_pc8 = epc8; v.e_bd = ebd; v.e_exc = eexc; v.e_pl = epl;
    return v;
  endfunction

  // reference model state
  stage_entry_t mq[$];
  logic [31:0]  hold_pc;
  logic         hold_bd;

  logic         r_rst, r_rq, r_cl, r_iv, r_bd, r_ordy, exp_rdy;
  logic [31:0]  r_pc;
  logic [4:0]   r_exc;
  logic [127:0] r_pl;
  stage_entry_t e;

  initial begin
    logic [127:0] p0, p1, p2, p3;
    p0 = pl_of(32'h3000);
    p1 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    p2 = pl_of(32'h3020);
    p3 = pl_of(32'h3004);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 128'h0, 1'b1);

    vecs[0]  = mk(1, 0, 0, 0, 32'h0,         0, 5'd0, 128'h0, 0, PC_RST,        32'h3008,      0, 5'd0, 128'h0);
    vecs[1]  = mk(1, 0, 0, 1, 32'h1234,      1, 5'd2, p1,     0, PC_RST,        32'h3008,      0, 5'd0, 128'h0);
    vecs[2]  = mk(0, 0, 0, 1, 32'h3000,      0, 5'd0, p0,     1, 32'h3000,      32'h3008,      0, 5'd0, p0);
    vecs[3]  = mk(0, 0, 0, 1, 32'h3004,      0, 5'd0, p3,     1, 32'h3004,      32'h300c,      0, 5'd0, p3);
    vecs[4]  = mk(0, 0, 0, 1, 32'h3008,      1, 5'd0, p1,     1, 32'h3008,      32'h3010,      1, 5'd0, p1);
    vecs[5]  = mk(0, 0, 0, 0, 32'h5555,      0, 5'd3, p2,     0, 32'h3008,      32'h3010,      1, 5'd0, 128'h0);
    vecs[6]  = mk(0, 0, 1, 1, 32'h3010,      1, 5'd3, p2,     0, 32'h3010,      32'h3018,      1, 5'd0, 128'h0);
    vecs[7]  = mk(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 5'd4, p1,     1, 32'hFFFF_FFFC, 32'h0000_0004, 0, 5'd4, p1);
    vecs[8]  = mk(0, 1, 0, 1, 32'h5000,      1, 5'd1, p0,     0, PC_VEC,        32'h4188,      0, 5'd0, 128'h0);
    vecs[9]  = mk(1, 1, 0, 0, 32'h0,         0, 5'd0, 128'h0, 0, PC_RST,        32'h3008,      0, 5'd0, 128'h0);
    vecs[10] = mk(0, 0, 0, 1, 32'h3020,      1, 5'd0, p2,     1, 32'h3020,      32'h3028,      1, 5'd0, p2);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,         0, 5'd0, 128'h0, 0, 32'h3020,      32'h3028,      1, 5'd0, 128'h0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].rq, vecs[i].cl, vecs[i].iv, vecs[i].pc, vecs[i].bd,
            vecs[i].exc, vecs[i].pl, 1'b1);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_pc8,
                vecs[i].e_bd, vecs[i].e_exc, vecs[i].e_pl, 1'b1);
    end

    // multi-cycle stall / flush sequences
    drive(1, 0, 0, 0, 32'h0, 0, 5'd0, 128'h0, 1); tick(); tick();
    hc("rst2", 0, PC_RST, 0, 128'h0, 1);
    drive(0, 0, 0, 1, 32'h3000, 0, 5'd0, pl_of(32'h3000), 1); tick();
    hc("st_a", 1, 32'h3000, 0, pl_of(32'h3000), 1);
`ifdef PIPE_STAGE_SKID_EN
    drive(0, 0, 0, 1, 32'h3004, 0, 5'd0, pl_of(32'h3004), 0); #1;
    chk("st_b.in_ready_pre", 128'(up_if.ready), 128'(1));
    tick();
    hc("st_b", 1, 32'h3000, 0, pl_of(32'h3000), 0);
    drive(0, 0, 0, 1, 32'h3008, 0, 5'd0, pl_of(32'h3008), 0); tick();
    hc("st_c", 1, 32'h3000, 0, pl_of(32'h3000), 0);
    drive(0, 0, 0, 1, 32'h3008, 0, 5'd0, pl_of(32'h3008), 1); #1;
    chk("st_d.in_ready_pre", 128'(up_if.ready), 128'(0));
    tick();
    hc("st_d", 1, 32'h3004, 0, pl_of(32'h3004), 1);
    tick();
    hc("st_e", 1, 32'h3008, 0, pl_of(32'h3008), 1);
    drive(0, 0, 0, 0, 32'h0, 0, 5'd0, 128'h0, 1); tick();
    hc("st_f", 0, 32'h3008, 0, 128'h0, 1);
    // req drops a full skid
    drive(0, 0, 0, 1, 32'h3100, 0, 5'd0, pl_of(32'h3100), 1); tick();
    drive(0, 0, 0, 1, 32'h3104, 0, 5'd0, pl_of(32'h3104), 0); tick();
    hc("rq_a", 1, 32'h3100, 0, pl_of(32'h3100), 0);
    drive(0, 1, 0, 0, 32'h0, 0, 5'd0, 128'h0, 0); tick();
    hc("rq_b", 0, PC_VEC, 0, 128'h0, 1);
    drive(0, 0, 0, 0, 32'h0, 0, 5'd0, 128'h0, 1); tick();
    hc("rq_c", 0, PC_VEC, 0, 128'h0, 1);
    // clr drops a full skid
    drive(0, 0, 0, 1, 32'h3200, 0, 5'd0, pl_of(32'h3200), 1); tick();
    drive(0, 0, 0, 1, 32'h3204, 0, 5'd0, pl_of(32'h3204), 0); tick();
    hc("cl_a", 1, 32'h3200, 0, pl_of(32'h3200), 0);
    drive(0, 0, 1, 1, 32'h3010, 1, 5'd0, pl_of(32'h3010), 0); tick();
    hc("cl_b", 0, 32'h3010, 1, 128'h0, 1);
    drive(0, 0, 0, 0, 32'h0, 0, 5'd0, 128'h0, 1); tick();
    hc("cl_c", 0, 32'h3010, 1, 128'h0, 1);
`else
    drive(0, 0, 0, 1, 32'h3004, 0, 5'd0, pl_of(32'h3004), 0); #1;
    chk("st_b.in_ready_pre", 128'(up_if.ready), 128'(0));
    tick();
    hc("st_b", 1, 32'h3000, 0, pl_of(32'h3000), 0);
    drive(0, 0, 0, 1, 32'h3004, 0, 5'd0, pl_of(32'h3004), 1); #1;
    chk("st_c.in_ready_pre", 128'(up_if.ready), 128'(1));
    tick();
    hc("st_c", 1, 32'h3004, 0, pl_of(32'h3004), 1);
    drive(0, 1, 0, 1, 32'h3008, 0, 5'd0, pl_of(32'h3008), 0); tick();
    hc("rq_a", 0, PC_VEC, 0, 128'h0, 1);
    drive(0, 0, 1, 0, 32'h3010, 1, 5'd0, pl_of(32'h3010), 0); tick();
    hc("cl_a", 0, 32'h3010, 1, 128'h0, 1);
`endif

    // random run against a FIFO model: the stage holds up to 1 (no skid) or 2 (skid) entries
    drive(1, 0, 0, 0, 32'h0, 0, 5'd0, 128'h0, 1); tick(); tick();
    mq.delete();
    hold_pc = PC_RST;
    hold_bd = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      r_rst  = ($urandom_range(0, 199) == 0);
      r_rq   = ($urandom_range(0, 31) == 0);
      r_cl   = ($urandom_range(0, 31) == 0);
      r_iv   = ($urandom_range(0, 9) < 7);
      r_ordy = ($urandom_range(0, 9) < 6);
      r_pc   = $urandom;
      r_bd   = 1'($urandom_range(0, 1));
      r_exc  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      r_pl   = {$urandom, $urandom, $urandom, $urandom};
      drive(r_rst, r_rq, r_cl, r_iv, r_pc, r_bd, r_exc, r_pl, r_ordy);
      #1;
      if (SKID) exp_rdy = (mq.size() < 2);
      else      exp_rdy = (mq.size() == 0) || r_ordy;
      if (mq.size() > 0)
        check_out($sformatf("rnd%0d", n), 1'b1, mq[0].pc, mq[0].pc + 32'd8, mq[0].bd,
                  mq[0].exc, mq[0].payload, exp_rdy);
      else
        check_out($sformatf("rnd%0d", n), 1'b0, hold_pc, hold_pc + 32'd8, hold_bd,
                  5'd0, 128'h0, exp_rdy);
      tick();
      if (r_rst) begin
        mq.delete(); hold_pc = PC_RST; hold_bd = 1'b0;
      end else if (r_rq) begin
        mq.delete(); hold_pc = PC_VEC; hold_bd = 1'b0;
      end else if (r_cl) begin
        mq.delete(); hold_pc = r_pc; hold_bd = r_bd;
      end else begin
        if (mq.size() > 0 && r_ordy) begin
          hold_pc = mq[0].pc;
          hold_bd = mq[0].bd;
          void'(mq.pop_front());
        end
        if (r_iv && exp_rdy) begin
          e.pc = r_pc; e.bd = r_bd; e.exc = r_exc; e.payload = r_pl;
          mq.push_back(e);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
